// File: rtl/ssc_pkg.sv
// ssc_pkg: shared constants for the ssc_net sequential sum calculator.
// State is one-hot; the ST_* constants are bit indices into the state vector
// and also the state flops' positions at the head of the scan chain.
package ssc_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int CHAIN_LEN = 64;
    localparam int N_STATES  = 5;

    localparam int ST_IDLE  = 0;
    localparam int ST_READ  = 1;
    localparam int ST_ACC   = 2;
    localparam int ST_WRITE = 3;
    localparam int ST_DONE  = 4;

    localparam logic [N_STATES-1:0] S_IDLE  = 5'b00001;
    localparam logic [N_STATES-1:0] S_READ  = 5'b00010;
    localparam logic [N_STATES-1:0] S_ACC   = 5'b00100;
    localparam logic [N_STATES-1:0] S_WRITE = 5'b01000;
    localparam logic [N_STATES-1:0] S_DONE  = 5'b10000;

    localparam logic [ADDR_W-1:0] LAST_READ_ADDR = 8'hFE;
    localparam logic [ADDR_W-1:0] RESULT_ADDR    = 8'hFF;

    // True when exactly one state bit is set; anything else is recovered to IDLE.
    function automatic logic state_legal(input logic [N_STATES-1:0] s);
        return $onehot(s);
    endfunction

endpackage

// File: rtl/ssc_scan_ff.sv
// ssc_scan_ff: one scan-chain cell. With SSC_SCAN_EN defined it is a mux-D
// flop (nbart selects si over d); otherwise a plain flop and si/nbart are
// don't-care. Reset is synchronous and wins over both modes.
module ssc_scan_ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic si,
    input  logic nbart,
    output logic q
);

    logic q_d;
    logic q_q;

    // Select functional data or the upstream chain bit.
`ifdef SSC_SCAN_EN
    always_comb begin
        q_d = nbart ? si : d;
    end
`else
    logic unused_scan;
    assign unused_scan = si ^ nbart;
    always_comb begin
        q_d = d;
    end
`endif

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) q_q <= RST_VAL;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/ssc_net.sv
// ssc_net: reads words from address 0 upward until a zero word or address
// 0xFE, then writes the 16-bit wrap-around sum to 0xFF and raises done.
// All 64 state bits live in ssc_scan_ff cells forming one chain:
// Si -> state[0..4], addr[0..7], acc[0..15], data[0..15], writeData[0..15],
// read_reg, write_reg, done -> SO.
// Optional feature macro: SSC_SCAN_EN (scan muxes present, SO driven).
module ssc_net
    import ssc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] readData,
    output logic [DATA_W-1:0] writeData,
    output logic [ADDR_W-1:0] addr,
    output logic              read_reg,
    output logic              write_reg,
    output logic              done,
    input  logic              Si,
    output logic              SO,
    input  logic              NbarT
);

    logic [N_STATES-1:0] state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                read_reg_q, read_reg_d;
    logic                write_reg_q, write_reg_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   sum;

    logic [CHAIN_LEN-1:0] chain_d;
    logic [CHAIN_LEN-1:0] chain_q;
    logic [CHAIN_LEN-1:0] scan_in;

    assign {done_q, write_reg_q, read_reg_q, wdata_q, data_q, acc_q, addr_q, state_q} = chain_q;
    assign chain_d = {done_d, write_reg_d, read_reg_d, wdata_d, data_d, acc_d, addr_d, state_d};
    assign scan_in = {chain_q[CHAIN_LEN-2:0], Si};

    assign sum = acc_q + data_q;

    // Next-state and datapath updates; every flop holds unless its state acts on it.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        acc_d       = acc_q;
        data_d      = data_q;
        wdata_d     = wdata_q;
        read_reg_d  = read_reg_q;
        write_reg_d = write_reg_q;
        done_d      = done_q;
        if (!state_legal(state_q)) begin
            state_d = S_IDLE;
        end else if (state_q[ST_IDLE]) begin
            if (start) begin
                addr_d     = '0;
                acc_d      = '0;
                done_d     = 1'b0;
                read_reg_d = 1'b1;
                state_d    = S_READ;
            end
        end else if (state_q[ST_READ]) begin
            data_d     = readData;
            read_reg_d = 1'b0;
            state_d    = S_ACC;
        end else if (state_q[ST_ACC]) begin
            if (data_q == '0 || addr_q == LAST_READ_ADDR) begin
                wdata_d     = sum;
                addr_d      = RESULT_ADDR;
                write_reg_d = 1'b1;
                state_d     = S_WRITE;
            end else begin
                acc_d      = sum;
                addr_d     = addr_q + 8'd1;
                read_reg_d = 1'b1;
                state_d    = S_READ;
            end
        end else if (state_q[ST_WRITE]) begin
            write_reg_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_DONE;
        end else begin
            // DONE: wait for start to drop so each run needs a fresh rising start.
            if (!start) state_d = S_IDLE;
        end
    end

    for (genvar i = 0; i < CHAIN_LEN; i++) begin : g_chain
        ssc_scan_ff #(
            .RST_VAL (i == ST_IDLE)
        ) u_ff (
            .clk   (clk),
            .rst   (rst),
            .d     (chain_d[i]),
            .si    (scan_in[i]),
            .nbart (NbarT),
            .q     (chain_q[i])
        );
    end

    assign writeData = wdata_q;
    assign addr      = addr_q;
    assign read_reg  = read_reg_q;
    assign write_reg = write_reg_q;
    assign done      = done_q;

`ifdef SSC_SCAN_EN
    assign SO = done_q;
`else
    assign SO = 1'b0;
`endif

endmodule

// File: tb/tb_ssc_net.sv
// tb_ssc_net: scoreboard bench for ssc_net. Each run pushes the expected read
// addresses and the expected result write into queues; a monitor pops and
// compares whenever read_reg or write_reg is seen. Scan tests are built only
// when SSC_SCAN_EN is defined.
module tb_ssc_net;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] readData;
    logic [15:0] writeData;
    logic [7:0]  addr;
    logic        read_reg;
    logic        write_reg;
    logic        done;
    logic        Si = 1'b0;
    logic        SO;
    logic        NbarT = 1'b0;

    logic [15:0] mem [0:255];
    logic [7:0]  exp_rd_q [$];
    logic [23:0] exp_wr_q [$];
    logic        mon_en = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    assign readData = mem[addr];

    ssc_net dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .readData  (readData),
        .writeData (writeData),
        .addr      (addr),
        .read_reg  (read_reg),
        .write_reg (write_reg),
        .done      (done),
        .Si        (Si),
        .SO        (SO),
        .NbarT     (NbarT)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic fail_extra(input string name, input logic [63:0] got);
        n_checks++;
        $display("FAIL %s: got 0x%0h, expected no transaction", name, got);
    endtask

    // Monitor: compare every strobe the DUT presents against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (mon_en && read_reg) begin
            if (exp_rd_q.size() == 0) fail_extra("rd_extra", {56'd0, addr});
            else check("rd_addr", {56'd0, addr}, {56'd0, exp_rd_q.pop_front()});
        end
        if (mon_en && write_reg) begin
            if (exp_wr_q.size() == 0) fail_extra("wr_extra", {40'd0, addr, writeData});
            else check("wr_addr_data", {40'd0, addr, writeData}, {40'd0, exp_wr_q.pop_front()});
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; NbarT = 1'b0; start = 1'b0; Si = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    // One full calculation: n_reads words consumed, exp_sum written to 0xFF.
    task automatic run(input string name, input int n_reads, input logic [15:0] exp_sum);
        int edges;
        for (int i = 0; i < n_reads; i++) exp_rd_q.push_back(8'(i));
        exp_wr_q.push_back({8'hFF, exp_sum});
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        while (done !== 1'b1 && edges < 2000) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({name, "_latency"}, 64'(edges), 64'(2 * n_reads + 2));
        check({name, "_done"}, {63'd0, done}, 64'd1);
        repeat (4) @(negedge clk);
        check({name, "_done_held"}, {63'd0, done}, 64'd1);
        check({name, "_queues_empty"}, 64'(exp_rd_q.size() + exp_wr_q.size()), 64'd0);
    endtask

    task automatic load_chain(input logic [63:0] v);
        @(negedge clk);
        NbarT = 1'b1;
        for (int k = 63; k >= 0; k--) begin
            Si = v[k];
            @(negedge clk);
        end
        Si = 1'b0;
    endtask

    task automatic unload_chain(output logic [63:0] v);
        NbarT = 1'b1;
        Si = 1'b0;
        for (int k = 63; k >= 0; k--) begin
            v[k] = SO;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [63:0] pat;
        logic [63:0] got;
        logic [63:0] ld;
        clear_mem();
        do_reset();

        check("rst_addr", {56'd0, addr}, 64'd0);
        check("rst_wdata", {48'd0, writeData}, 64'd0);
        check("rst_strobes_done", {61'd0, read_reg, write_reg, done}, 64'd0);
        check("rst_so", {63'd0, SO}, 64'd0);

`ifdef SSC_SCAN_EN
        pat = 64'hA5A5_A5A5_A5A5_A5A5;
        load_chain(pat);
        unload_chain(got);
        check("scan_a5_roundtrip", got, pat);
        do_reset();
`endif

        mon_en = 1'b1;
        mem[0] = 16'd5; mem[1] = 16'd7; mem[2] = 16'd0;
        run("sum_5_7", 3, 16'd12);

        mem[0] = 16'hFFFF; mem[1] = 16'd2; mem[2] = 16'd0;
        run("wrap", 3, 16'h0001);

        mem[0] = 16'd0;
        run("zero_first", 1, 16'h0000);
        repeat (6) @(negedge clk);
        check("zero_first_no_reads", 64'(exp_rd_q.size()), 64'd0);

        for (int i = 0; i < 255; i++) mem[i] = 16'(i + 1);
        mem[255] = 16'h0000;
        run("full_range", 255, 16'h7F80);

`ifndef SSC_SCAN_EN
        check("so_tied_low", {63'd0, SO}, 64'd0);
`endif

`ifdef SSC_SCAN_EN
        // Illegal all-zero state: one functional edge recovers IDLE and holds the rest.
        mon_en = 1'b0;
        ld = {1'b1, 1'b0, 1'b1, 16'hBEEF, 16'h0000, 16'h1234, 8'h3C, 5'b00000};
        load_chain(ld);
        NbarT = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("illegal_addr_hold", {56'd0, addr}, 64'h3C);
        check("illegal_wdata_hold", {48'd0, writeData}, 64'hBEEF);
        check("illegal_strobes_hold", {61'd0, read_reg, write_reg, done}, 64'b101);
        unload_chain(got);
        check("illegal_chain", got, {ld[63:5], 5'b00001});
        do_reset();
`endif

        // Reset while in ACC with test mode requested: reset must win.
        mon_en = 1'b1;
        clear_mem();
        mem[0] = 16'd5; mem[1] = 16'd7;
        exp_rd_q.push_back(8'd0);
        exp_rd_q.push_back(8'd1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_addr", {56'd0, addr}, 64'd1);
        rst = 1'b1; NbarT = 1'b1; Si = 1'b1;
        @(negedge clk);
        rst = 1'b0; Si = 1'b0;
        check("midrst_addr", {56'd0, addr}, 64'd0);
        check("midrst_wdata", {48'd0, writeData}, 64'd0);
        check("midrst_strobes_done", {61'd0, read_reg, write_reg, done}, 64'd0);
        check("midrst_so", {63'd0, SO}, 64'd0);
        check("midrst_reads_seen", 64'(exp_rd_q.size()), 64'd0);
`ifdef SSC_SCAN_EN
        mon_en = 1'b0;
        unload_chain(got);
        check("midrst_chain", got, 64'd1);
        do_reset();
        mon_en = 1'b1;
`else
        NbarT = 1'b0;
`endif
        mem[2] = 16'd0;
        run("after_rst", 3, 16'd12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
